// File: rtl/ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcode/funct values, ALU codes,
// the mult/div FSM state type and the control-word bundles carried down the pipe.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    localparam int ALU_CODE_W = 5;
    typedef logic [ALU_CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_NOP   = 5'd0;
    localparam alu_code_t ALU_ADD   = 5'd1;
    localparam alu_code_t ALU_SUB   = 5'd2;
    localparam alu_code_t ALU_AND   = 5'd3;
    localparam alu_code_t ALU_OR    = 5'd4;
    localparam alu_code_t ALU_XOR   = 5'd5;
    localparam alu_code_t ALU_NOR   = 5'd6;
    localparam alu_code_t ALU_SLT   = 5'd7;
    localparam alu_code_t ALU_SLTU  = 5'd8;
    localparam alu_code_t ALU_SLL   = 5'd9;
    localparam alu_code_t ALU_SRL   = 5'd10;
    localparam alu_code_t ALU_SRA   = 5'd11;
    localparam alu_code_t ALU_LUI   = 5'd12;
    localparam alu_code_t ALU_MULT  = 5'd13;
    localparam alu_code_t ALU_MULTU = 5'd14;
    localparam alu_code_t ALU_DIV   = 5'd15;
    localparam alu_code_t ALU_DIVU  = 5'd16;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Controls that live in ID/EX; branch/jump are consumed in ID and never registered.
    typedef struct packed {
        alu_code_t aluctl;
        logic      alusrc;
        logic      regdst;
        logic      regwrite;
        logic      memread;
        logic      memwrite;
        logic      memtoreg;
        logic      muldiv;
    } ex_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memwrite;
        logic memread;
        logic memtoreg;
        logic hilo_we;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    function automatic logic is_div(input alu_code_t code);
        return (code == ALU_DIV) || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder; unknown encodings produce an all-zero (NOP) word.
// Mult/div functs are decoded only when CTRL_MULDIV_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       branch,
    output logic       jump,
    output ex_ctrl_t   ex
);

    always_comb begin
        branch = 1'b0;
        jump   = 1'b0;
        ex     = '0;
        case (op)
            OP_RTYPE: begin
                ex.regwrite = 1'b1;
                ex.regdst   = 1'b1;
                case (funct)
                    F_ADD, F_ADDU:  ex.aluctl = ALU_ADD;
                    F_SUB, F_SUBU:  ex.aluctl = ALU_SUB;
                    F_AND:          ex.aluctl = ALU_AND;
                    F_OR:           ex.aluctl = ALU_OR;
                    F_XOR:          ex.aluctl = ALU_XOR;
                    F_NOR:          ex.aluctl = ALU_NOR;
                    F_SLT:          ex.aluctl = ALU_SLT;
                    F_SLTU:         ex.aluctl = ALU_SLTU;
                    F_SLL:          ex.aluctl = ALU_SLL;
                    F_SRL:          ex.aluctl = ALU_SRL;
                    F_SRA:          ex.aluctl = ALU_SRA;
                    F_MFHI, F_MFLO: ex.aluctl = ALU_NOP;
                    F_JR: begin
                        ex   = '0;
                        jump = 1'b1;
                    end
`ifdef CTRL_MULDIV_EN
                    // Mult/div writes HI/LO only, never the register file.
                    F_MULT:  ex = '{aluctl: ALU_MULT,  muldiv: 1'b1, default: 1'b0};
                    F_MULTU: ex = '{aluctl: ALU_MULTU, muldiv: 1'b1, default: 1'b0};
                    F_DIV:   ex = '{aluctl: ALU_DIV,   muldiv: 1'b1, default: 1'b0};
                    F_DIVU:  ex = '{aluctl: ALU_DIVU,  muldiv: 1'b1, default: 1'b0};
`endif
                    default: ex = '0;
                endcase
            end
            OP_LW: begin
                ex.aluctl   = ALU_ADD;
                ex.alusrc   = 1'b1;
                ex.regwrite = 1'b1;
                ex.memread  = 1'b1;
                ex.memtoreg = 1'b1;
            end
            OP_SW: begin
                ex.aluctl   = ALU_ADD;
                ex.alusrc   = 1'b1;
                ex.memwrite = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ex.aluctl = ALU_SUB;
                branch    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ex.alusrc   = 1'b1;
                ex.regwrite = 1'b1;
                case (op)
                    OP_SLTI:  ex.aluctl = ALU_SLT;
                    OP_SLTIU: ex.aluctl = ALU_SLTU;
                    OP_ANDI:  ex.aluctl = ALU_AND;
                    OP_ORI:   ex.aluctl = ALU_OR;
                    OP_XORI:  ex.aluctl = ALU_XOR;
                    OP_LUI:   ex.aluctl = ALU_LUI;
                    default:  ex.aluctl = ALU_ADD;
                endcase
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump        = 1'b1;
                ex.regwrite = 1'b1;
            end
            default: ex = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// MIPS pipeline control path: decode, ID/EX, EX/MEM, MEM/WB control registers and
// the mult/div occupancy FSM, which is built only when CTRL_MULDIV_EN is defined.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W    = 5,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                stallE,
    input  logic                flushE,
    input  logic                flushM,
    output logic                branchD,
    output logic                jumpD,
    output logic [ALUCTL_W-1:0] aluctlE,
    output logic                alusrcE,
    output logic                regdstE,
    output logic                regwriteE,
    output logic                memreadE,
    output logic                memtoregE,
    output logic                regwriteM,
    output logic                memwriteM,
    output logic                memreadM,
    output logic                memtoregM,
    output logic                hilo_weM,
    output logic                regwriteW,
    output logic                memtoregW,
    output logic                md_busy
);

    ex_ctrl_t  dec;
    ex_ctrl_t  idex_q;
    mem_ctrl_t exmem_q;
    wb_ctrl_t  memwb_q;
    logic      hilo_we_ex;

    ctrl_decode u_decode (
        .op     (op),
        .funct  (funct),
        .branch (branchD),
        .jump   (jumpD),
        .ex     (dec)
    );

`ifdef CTRL_MULDIV_EN
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX) + 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // md_busy is a stall request: while high, ID/EX holds and EX/MEM takes a bubble.
    // The IDLE cycle with a mult/div in EX counts as the first busy cycle, so the
    // counter is preloaded with N-2 to give exactly N busy cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_busy    = 1'b0;
        hilo_we_ex = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (idex_q.muldiv) begin
                    md_busy = 1'b1;
                    if (!flushE) begin
                        state_d = MD_BUSY;
                        cnt_d   = is_div(idex_q.aluctl) ? DIV_LOAD : MULT_LOAD;
                    end
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (flushE) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MD_DONE: begin
                state_d    = MD_IDLE;
                hilo_we_ex = idex_q.muldiv && !flushE;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    localparam int UNUSED_MD_CYCLES = MULT_CYCLES + DIV_CYCLES;
    logic unused_muldiv;

    assign unused_muldiv = idex_q.muldiv;
    assign md_busy       = 1'b0;
    assign hilo_we_ex    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else if (flushE) begin
            idex_q <= '0;
        end else if (!(md_busy || stallE)) begin
            idex_q <= dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= '0;
        end else if (flushM || md_busy) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= '{regwrite: idex_q.regwrite, memwrite: idex_q.memwrite,
                         memread:  idex_q.memread,  memtoreg: idex_q.memtoreg,
                         hilo_we:  hilo_we_ex};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_q <= '0;
        end else begin
            memwb_q <= '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg};
        end
    end

    assign aluctlE   = ALUCTL_W'(idex_q.aluctl);
    assign alusrcE   = idex_q.alusrc;
    assign regdstE   = idex_q.regdst;
    assign regwriteE = idex_q.regwrite;
    assign memreadE  = idex_q.memread;
    assign memtoregE = idex_q.memtoreg;

    assign regwriteM = exmem_q.regwrite;
    assign memwriteM = exmem_q.memwrite;
    assign memreadM  = exmem_q.memread;
    assign memtoregM = exmem_q.memtoreg;
    assign hilo_weM  = exmem_q.hilo_we;

    assign regwriteW = memwb_q.regwrite;
    assign memtoregW = memwb_q.memtoreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: decode table, stage latency, stall/flush,
// asynchronous reset, and the mult/div sequence when CTRL_MULDIV_EN is defined.
module tb_ctrl_pipeline;

    localparam int ALUCTL_W    = 5;
    localparam int MULT_CYCLES = 4;
    localparam int DIV_CYCLES  = 32;
    localparam int EXP_W       = 13;   // {alu[4:0], src, dst, rw, mr, mw, m2r, br, j}

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [5:0]          op = 6'h3f;
    logic [5:0]          funct = 6'h00;
    logic                stallE = 1'b0;
    logic                flushE = 1'b0;
    logic                flushM = 1'b0;
    logic                branchD, jumpD;
    logic [ALUCTL_W-1:0] aluctlE;
    logic                alusrcE, regdstE, regwriteE, memreadE, memtoregE;
    logic                regwriteM, memwriteM, memreadM, memtoregM, hilo_weM;
    logic                regwriteW, memtoregW, md_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [5:0]       tbl_op[$];
    logic [5:0]       tbl_funct[$];
    logic [EXP_W-1:0] tbl_exp[$];

    ctrl_pipeline #(
        .ALUCTL_W    (ALUCTL_W),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .stallE    (stallE),
        .flushE    (flushE),
        .flushM    (flushM),
        .branchD   (branchD),
        .jumpD     (jumpD),
        .aluctlE   (aluctlE),
        .alusrcE   (alusrcE),
        .regdstE   (regdstE),
        .regwriteE (regwriteE),
        .memreadE  (memreadE),
        .memtoregE (memtoregE),
        .regwriteM (regwriteM),
        .memwriteM (memwriteM),
        .memreadM  (memreadM),
        .memtoregM (memtoregM),
        .hilo_weM  (hilo_weM),
        .regwriteW (regwriteW),
        .memtoregW (memtoregW),
        .md_busy   (md_busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [17:0] all_outs();
        return {aluctlE, alusrcE, regdstE, regwriteE, memreadE, memtoregE,
                regwriteM, memwriteM, memreadM, memtoregM, hilo_weM,
                regwriteW, memtoregW, md_busy};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    task automatic flush_pipe();
        set_instr(6'h3f, 6'h00);
        stallE = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        repeat (3) step();
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] alu, input logic [7:0] flags);
        tbl_op.push_back(o);
        tbl_funct.push_back(f);
        tbl_exp.push_back({alu, flags});
    endtask

    task automatic build_table();
        add(6'h00, 6'h20, 5'd1,  8'b01100000);  // ADD
        add(6'h00, 6'h21, 5'd1,  8'b01100000);  // ADDU
        add(6'h00, 6'h22, 5'd2,  8'b01100000);  // SUB
        add(6'h00, 6'h23, 5'd2,  8'b01100000);  // SUBU
        add(6'h00, 6'h24, 5'd3,  8'b01100000);  // AND
        add(6'h00, 6'h25, 5'd4,  8'b01100000);  // OR
        add(6'h00, 6'h26, 5'd5,  8'b01100000);  // XOR
        add(6'h00, 6'h27, 5'd6,  8'b01100000);  // NOR
        add(6'h00, 6'h2a, 5'd7,  8'b01100000);  // SLT
        add(6'h00, 6'h2b, 5'd8,  8'b01100000);  // SLTU
        add(6'h00, 6'h00, 5'd9,  8'b01100000);  // SLL
        add(6'h00, 6'h02, 5'd10, 8'b01100000);  // SRL
        add(6'h00, 6'h03, 5'd11, 8'b01100000);  // SRA
        add(6'h00, 6'h10, 5'd0,  8'b01100000);  // MFHI
        add(6'h00, 6'h12, 5'd0,  8'b01100000);  // MFLO
        add(6'h00, 6'h08, 5'd0,  8'b00000001);  // JR
        add(6'h23, 6'h25, 5'd1,  8'b10110100);  // LW
        add(6'h2b, 6'h25, 5'd1,  8'b10001000);  // SW
        add(6'h04, 6'h25, 5'd2,  8'b00000010);  // BEQ
        add(6'h05, 6'h25, 5'd2,  8'b00000010);  // BNE
        add(6'h08, 6'h25, 5'd1,  8'b10100000);  // ADDI
        add(6'h09, 6'h25, 5'd1,  8'b10100000);  // ADDIU
        add(6'h0a, 6'h25, 5'd7,  8'b10100000);  // SLTI
        add(6'h0b, 6'h25, 5'd8,  8'b10100000);  // SLTIU
        add(6'h0c, 6'h25, 5'd3,  8'b10100000);  // ANDI
        add(6'h0d, 6'h25, 5'd4,  8'b10100000);  // ORI
        add(6'h0e, 6'h25, 5'd5,  8'b10100000);  // XORI
        add(6'h0f, 6'h25, 5'd12, 8'b10100000);  // LUI
        add(6'h02, 6'h25, 5'd0,  8'b00000001);  // J
        add(6'h03, 6'h25, 5'd0,  8'b00100001);  // JAL
        add(6'h3f, 6'h00, 5'd0,  8'b00000000);  // unknown opcode
        add(6'h11, 6'h20, 5'd0,  8'b00000000);  // unknown opcode
        add(6'h00, 6'h3f, 5'd0,  8'b00000000);  // unknown funct
`ifndef CTRL_MULDIV_EN
        add(6'h00, 6'h18, 5'd0,  8'b00000000);  // MULT as NOP
        add(6'h00, 6'h19, 5'd0,  8'b00000000);  // MULTU as NOP
        add(6'h00, 6'h1a, 5'd0,  8'b00000000);  // DIV as NOP
        add(6'h00, 6'h1b, 5'd0,  8'b00000000);  // DIVU as NOP
`endif
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (md_busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_instr(6'h00, 6'h20);
        repeat (2) step();
        n_tests++;
        if (all_outs() !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
        flush_pipe();
    endtask

    // scoreboard: expected words queued at drive time, popped as WB catches up
    task automatic test_decode_stream(input int count);
        logic [EXP_W-1:0] e_ex, e_m, e_w;
        flush_pipe();
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        for (int i = 0; i < count; i++) begin
            int k;
            k = $urandom_range(0, tbl_op.size() - 1);
            set_instr(tbl_op[k], tbl_funct[k]);
            #1;
            n_tests++;
            if ({branchD, jumpD} !== tbl_exp[k][1:0]) begin
                n_fail++;
                $display("FAIL decode_id op=%h funct=%h: got %b expected %b",
                         tbl_op[k], tbl_funct[k], {branchD, jumpD}, tbl_exp[k][1:0]);
            end
            exp_q.push_back(tbl_exp[k]);
            step();
            e_ex = exp_q[2];
            e_m  = exp_q[1];
            e_w  = exp_q.pop_front();
            n_tests++;
            if ({aluctlE, alusrcE, regdstE, regwriteE, memreadE, memtoregE} !==
                {e_ex[12:8], e_ex[7:4], e_ex[2]}) begin
                n_fail++;
                $display("FAIL ex_stage op=%h funct=%h: got %b expected %b", tbl_op[k], tbl_funct[k],
                         {aluctlE, alusrcE, regdstE, regwriteE, memreadE, memtoregE},
                         {e_ex[12:8], e_ex[7:4], e_ex[2]});
            end
            n_tests++;
            if ({regwriteM, memreadM, memwriteM, memtoregM, hilo_weM} !==
                {e_m[5], e_m[4], e_m[3], e_m[2], 1'b0}) begin
                n_fail++;
                $display("FAIL mem_stage: got %b expected %b",
                         {regwriteM, memreadM, memwriteM, memtoregM, hilo_weM},
                         {e_m[5], e_m[4], e_m[3], e_m[2], 1'b0});
            end
            n_tests++;
            if ({regwriteW, memtoregW} !== {e_w[5], e_w[2]}) begin
                n_fail++;
                $display("FAIL wb_stage: got %b expected %b", {regwriteW, memtoregW}, {e_w[5], e_w[2]});
            end
        end
    endtask

    task automatic test_add_latency();
        logic [2:0] pat;
        flush_pipe();
        set_instr(6'h00, 6'h20);
        for (int c = 0; c < 4; c++) begin
            step();
            set_instr(6'h3f, 6'h00);
            pat = 3'b100 >> c;
            n_tests++;
            if ({regwriteE, regwriteM, regwriteW} !== pat) begin
                n_fail++;
                $display("FAIL add_latency cycle %0d: got %b expected %b",
                         c + 1, {regwriteE, regwriteM, regwriteW}, pat);
            end
        end
    endtask

    // The hazard unit pairs flushM with stallE so the held load is not duplicated into MEM.
    task automatic test_lw_stall();
        int held;
        int mem_hits;
        int hit_cycle;
        flush_pipe();
        set_instr(6'h23, 6'h00);
        step();
        set_instr(6'h3f, 6'h00);
        held = 0;
        mem_hits = 0;
        hit_cycle = -1;
        for (int c = 0; c < 5; c++) begin
            if (memreadE === 1'b1) held++;
            if (memreadM === 1'b1) begin
                mem_hits++;
                hit_cycle = c;
            end
            stallE = (c < 2);
            flushM = (c < 2);
            step();
        end
        stallE = 1'b0;
        flushM = 1'b0;
        n_tests++;
        if (held !== 3) begin
            n_fail++;
            $display("FAIL lw_stall_hold: memreadE high %0d cycles expected 3", held);
        end
        n_tests++;
        if (mem_hits !== 1 || hit_cycle !== 3) begin
            n_fail++;
            $display("FAIL lw_stall_mem: memreadM hits %0d at %0d expected 1 at 3", mem_hits, hit_cycle);
        end
    endtask

    task automatic test_flush();
        flush_pipe();
        set_instr(6'h23, 6'h00);
        flushE = 1'b1;
        step();
        flushE = 1'b0;
        n_tests++;
        if ({aluctlE, alusrcE, regwriteE, memreadE, memtoregE} !== 9'd0) begin
            n_fail++;
            $display("FAIL flush_e: got %b expected 0", {aluctlE, alusrcE, regwriteE, memreadE, memtoregE});
        end
        step();
        set_instr(6'h3f, 6'h00);
        flushM = 1'b1;
        step();
        flushM = 1'b0;
        n_tests++;
        if ({regwriteM, memreadM, memtoregM, regwriteE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_m: got %b expected 0000", {regwriteM, memreadM, memtoregM, regwriteE});
        end
    endtask

    task automatic test_async_reset();
        flush_pipe();
        set_instr(6'h00, 6'h20);
        step();
        set_instr(6'h23, 6'h00);
        step();
        n_tests++;
        if ({memreadE, regwriteM} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_reset_load: got %b expected 11", {memreadE, regwriteM});
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", all_outs());
        end
        step();
        n_tests++;
        if (all_outs() !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

`ifdef CTRL_MULDIV_EN
    task automatic test_div();
        int n;
        int bad;
        flush_pipe();
        set_instr(6'h00, 6'h1a);
        step();
        set_instr(6'h23, 6'h00);
        n = 0;
        bad = 0;
        while (md_busy === 1'b1 && n < 200) begin
            n++;
            if (memreadM !== 1'b0 || regwriteM !== 1'b0 || hilo_weM !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (n !== DIV_CYCLES) begin
            n_fail++;
            $display("FAIL div_busy_len: got %0d expected %0d", n, DIV_CYCLES);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL div_bubbles: got %0d non-bubble cycles expected 0", bad);
        end
        step();
        n_tests++;
        if ({hilo_weM, memreadE, md_busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL div_hilo: got %b expected 110", {hilo_weM, memreadE, md_busy});
        end
        step();
        n_tests++;
        if ({hilo_weM, memreadM} !== 2'b01) begin
            n_fail++;
            $display("FAIL div_after: got %b expected 01", {hilo_weM, memreadM});
        end
    endtask

    task automatic test_mult_flush();
        int hilo_seen;
        flush_pipe();
        set_instr(6'h00, 6'h18);
        step();
        set_instr(6'h3f, 6'h00);
        step();
        flushE = 1'b1;
        #1;
        n_tests++;
        if (md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_busy_2nd: got %b expected 1", md_busy);
        end
        step();
        flushE = 1'b0;
        n_tests++;
        if ({md_busy, aluctlE} !== 6'd0) begin
            n_fail++;
            $display("FAIL mult_flush: got %b expected 0", {md_busy, aluctlE});
        end
        hilo_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (hilo_weM !== 1'b0 || md_busy !== 1'b0) hilo_seen++;
            step();
        end
        n_tests++;
        if (hilo_seen !== 0) begin
            n_fail++;
            $display("FAIL mult_flush_quiet: got %0d active cycles expected 0", hilo_seen);
        end
    endtask

    task automatic test_reset_busy();
        int n;
        flush_pipe();
        set_instr(6'h00, 6'h18);
        step();
        set_instr(6'h3f, 6'h00);
        step();
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== 18'd0) begin
            n_fail++;
            $display("FAIL busy_reset: got %h expected 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_tests++;
        if ({md_busy, hilo_weM} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_reset_resume: got %b expected 00", {md_busy, hilo_weM});
        end
        set_instr(6'h00, 6'h18);
        step();
        set_instr(6'h3f, 6'h00);
        count_busy(n);
        n_tests++;
        if (n !== MULT_CYCLES) begin
            n_fail++;
            $display("FAIL busy_reset_mult_len: got %0d expected %0d", n, MULT_CYCLES);
        end
        step();
        n_tests++;
        if (hilo_weM !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_reset_hilo: got %b expected 1", hilo_weM);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        flush_pipe();
        set_instr(6'h00, 6'h18);
        step();
        set_instr(6'h00, 6'h19);
        count_busy(n1);
        step();
        set_instr(6'h3f, 6'h00);
        n_tests++;
        if ({hilo_weM, md_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_handoff: got %b expected 11", {hilo_weM, md_busy});
        end
        count_busy(n2);
        n_tests++;
        if (n1 !== MULT_CYCLES || n2 !== MULT_CYCLES) begin
            n_fail++;
            $display("FAIL b2b_len: got %0d,%0d expected %0d,%0d", n1, n2, MULT_CYCLES, MULT_CYCLES);
        end
        step();
        n_tests++;
        if (hilo_weM !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hilo2: got %b expected 1", hilo_weM);
        end
    endtask
`else
    task automatic test_muldiv_disabled();
        int active;
        flush_pipe();
        set_instr(6'h00, 6'h1a);
        step();
        n_tests++;
        if ({aluctlE, alusrcE, regdstE, regwriteE, memreadE, memtoregE, md_busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL div_disabled_ex: got %b expected 0",
                     {aluctlE, alusrcE, regdstE, regwriteE, memreadE, memtoregE, md_busy});
        end
        set_instr(6'h00, 6'h18);
        active = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (md_busy !== 1'b0 || hilo_weM !== 1'b0 || aluctlE !== '0) active++;
        end
        n_tests++;
        if (active !== 0) begin
            n_fail++;
            $display("FAIL muldiv_disabled_quiet: got %0d active cycles expected 0", active);
        end
    endtask
`endif

    initial begin
        build_table();
        test_reset();
        test_add_latency();
        test_lw_stall();
        test_flush();
        test_decode_stream(60);
        test_async_reset();
`ifdef CTRL_MULDIV_EN
        test_div();
        test_mult_flush();
        test_reset_busy();
        test_back_to_back();
`else
        test_muldiv_disabled();
`endif
        test_decode_stream(20);
        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have parameter ALUCTL_W, default 5, width of the ALU control code.
REQ-002 SHALL have parameter MULT_CYCLES, default 4, EX occupancy of MULT/MULTU (>=2).
REQ-003 SHALL have parameter DIV_CYCLES, default 32, EX occupancy of DIV/DIVU (>=2).
REQ-004 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- op  in  6  ID opcode.
- funct  in  6  ID funct field.
- stallE  in  1  hold ID/EX register.
- flushE  in  1  bubble into ID/EX.
- flushM  in  1  bubble into EX/MEM.
- branchD, jumpD  out  1  ID decode.
- aluctlE  out  ALUCTL_W  EX ALU code.
- alusrcE, regdstE, regwriteE, memreadE, memtoregE  out  1  EX controls.
- regwriteM, memwriteM, memreadM, memtoregM, hilo_weM  out  1  MEM controls.
- regwriteW, memtoregW  out  1  WB controls.
- md_busy  out  1  stall request to hazard unit.

Function
REQ-005 SHALL decode op/funct combinationally in ID for the team MIPS subset; unknown encodings SHALL decode to all-zero (NOP) controls.
REQ-006 SHALL carry controls through ID/EX, EX/MEM, MEM/WB registers; latency ID->EX, EX->MEM, MEM->WB is one cycle each.
REQ-007 ID/EX priority: flushE (load zeros) > md_busy or stallE (hold) > load.
REQ-008 EX/MEM priority: flushM (zeros) > md_busy (zeros, bubble) > load from EX.
REQ-009 MEM/WB SHALL load every cycle, never stalled.
REQ-010 SHALL keep the mult/div FSM in states IDLE, BUSY, DONE.
REQ-011 IDLE -> BUSY when the EX instruction is MULT/MULTU/DIV/DIVU and flushE=0; counter loads N-2 (N = MULT_CYCLES or DIV_CYCLES).
REQ-012 BUSY: counter decrements each cycle; at count 0 -> DONE.
REQ-013 DONE -> IDLE unconditionally; in DONE the instruction passes to MEM with hilo_weM set next cycle, and SHALL NOT re-trigger.
REQ-014 md_busy = (IDLE and mult/div in EX) or BUSY, giving exactly N busy cycles per op.
REQ-015 flushE in BUSY or DONE SHALL force IDLE next cycle, clear ID/EX, and produce no hilo_weM.
REQ-016 Back-to-back mult/div: the second op enters EX after DONE and starts its own full sequence.

Reset
REQ-017 While rst=0, all pipeline registers SHALL be 0, FSM IDLE, counter 0; all registered outputs 0 and md_busy=0, asynchronously.
REQ-018 Reset deasserting mid-operation SHALL resume from IDLE with no pending hilo write.

Configuration
REQ-019 Macro CTRL_MULDIV_EN: defined -> FSM, counter, hilo_weM and md_busy behave as above.
REQ-020 CTRL_MULDIV_EN undefined -> mult/div decode as NOP, no FSM, md_busy and hilo_weM tied 0.

Structure
REQ-021 Opcode/funct constants, ALU code constants, FSM state typedef and control-word bundle typedef SHALL live in shared package ctrl_pkg.
REQ-022 Decode SHALL be one sub-module, ctrl_decode; registers and FSM stay in ctrl_pipeline.

Verification
REQ-023 ADD in ID, no stalls -> regwriteE=1 at +1, regwriteM=1 at +2, regwriteW=1 at +3.
REQ-024 LW in ID with stallE=1 for 2 cycles -> memreadE held 1 for 3 cycles, memreadM=1 once, on cycle after release.
REQ-025 DIV entering EX, DIV_CYCLES=32 -> md_busy high exactly 32 cycles, memreadM/regwriteM bubbles meanwhile, hilo_weM=1 for one cycle after.
REQ-026 MULT (MULT_CYCLES=4) with flushE asserted on 2nd busy cycle -> md_busy low next cycle, aluctlE=0, hilo_weM never set.
REQ-027 rst=0 pulse during BUSY -> all outputs 0 immediately; after release, new MULT gives full 4-cycle md_busy.
REQ-028 CTRL_MULDIV_EN undefined, DIV in ID -> all EX controls 0, md_busy stays 0.
